permutation_sequencer: RTL
==========================

PERMUTATION_SEQUENCER -- requirements
Module: permutation_sequencer

Interface
REQ-001: The module SHALL import ascon_pack and expose parameter NB_ROUNDS_A, default 12, number of rounds for p^a (legal range 1..12).
REQ-002: The module SHALL expose parameter NB_ROUNDS_B, default 6, number of rounds for p^b (legal range 1..12).
REQ-003: The module SHALL have port clock_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004: The module SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005: The module SHALL have port start_i, input, 1 bit: permutation request, accepted only when ready_o=1.
REQ-006: The module SHALL have port mode_i, input, 1 bit: 0 selects p^a, 1 selects p^b; sampled only on acceptance.
REQ-007: The module SHALL have port ready_o, output, 1 bit: high only in IDLE.
REQ-008: The module SHALL have port round_o, output, 4 bits: round index driven to the constant-addition round_i input.
REQ-009: The module SHALL have port sel_init_o, output, 1 bit: 1 selects the external initial state into the round logic; 0 selects the state register.
REQ-010: The module SHALL have port en_state_o, output, 1 bit: state-register capture enable.
REQ-011: The module SHALL have port busy_o, output, 1 bit: high in FIRST and ROUND.
REQ-012: The module SHALL have port done_o, output, 1 bit: one-cycle pulse when the permutation result is valid in the state register.

Function
REQ-013: The FSM SHALL have exactly four states: IDLE, FIRST, ROUND, DONE; round_o SHALL come from a registered 4-bit counter.
REQ-014: In IDLE, start_i=1 SHALL latch mode_i, load the counter with 12-NB_ROUNDS_A (mode 0) or 12-NB_ROUNDS_B (mode 1), and move to FIRST; with start_i=0, IDLE SHALL hold and the counter SHALL stay at 0.
REQ-015: FIRST SHALL drive sel_init_o=1 and en_state_o=1 for exactly one cycle, using the loaded round_o.
REQ-016: On leaving FIRST, the FSM SHALL go to DONE if the counter equals 11; otherwise it SHALL increment the counter and go to ROUND.
REQ-017: ROUND SHALL drive sel_init_o=0 and en_state_o=1 each cycle; if the counter equals 11 the FSM SHALL move to DONE, otherwise it SHALL increment the counter and remain in ROUND.
REQ-018: The counter SHALL never exceed 11 and SHALL never wrap; round_o SHALL take values start..11 in strictly increasing order, one per enabled cycle.
REQ-019: en_state_o SHALL be asserted exactly N cycles per permutation (N=NB_ROUNDS_A or NB_ROUNDS_B), and always contiguously.
REQ-020: DONE SHALL last one cycle with done_o=1, en_state_o=0, sel_init_o=0, ready_o=0, then return to IDLE with the counter cleared to 0.
REQ-021: Latency SHALL be fixed: start accepted at edge T gives FIRST in cycle T+1 and DONE in cycle T+N+1; the next start can be accepted in cycle T+N+2.
REQ-022: start_i and mode_i SHALL be ignored in FIRST, ROUND and DONE; a change to mode_i mid-operation SHALL NOT alter the round count.
REQ-023: Outputs SHALL be decoded from state and counter registers only, with no combinational path from start_i or mode_i to any output.
REQ-024: sel_init_o and en_state_o SHALL be 0 in IDLE and DONE.

Reset
REQ-025: While reset_i=1 at a rising edge, the next state SHALL be IDLE and the counter and latched mode SHALL be 0, regardless of current state or start_i.
REQ-026: After reset, outputs SHALL be ready_o=1, round_o=0, sel_init_o=0, en_state_o=0, busy_o=0, done_o=0.
REQ-027: Reset asserted during FIRST or ROUND SHALL abort the operation with no done_o pulse; a start_i held high during reset SHALL be accepted only at the first edge with reset_i=0.

Verification
REQ-028: Reset, then start_i=1 with mode_i=0 for 1 cycle -> sel_init_o=1 in cycle 1 only; round_o=0,1,...,11 over 12 cycles with en_state_o=1; done_o=1 in cycle 13; ready_o=1 in cycle 14.
REQ-029: start_i=1 with mode_i=1 -> round_o=6..11, en_state_o high for 6 cycles, done_o 7 cycles after acceptance.
REQ-030: Feed the datapath (constant addition, substitution, diffusion) with the ASCON initial state (IV=0x80400c0600000000, key and nonce 0) under mode 0 -> the state register at done_o equals the p^12 reference model output.
REQ-031: Toggle mode_i and pulse start_i during ROUND -> no restart, unchanged round sequence, and exactly one done_o per accepted start.
REQ-032: Assert reset_i at round_o=5 of a p^a run -> IDLE next cycle, all outputs at reset values, no done_o; a new start then runs a full 12 rounds.
REQ-033: Hold start_i=1 continuously with mode_i=1 -> back-to-back permutations every 8 cycles (6 ROUND-capable cycles plus DONE plus IDLE), ready_o high for exactly one cycle between them.

Source files
------------

// File: rtl/permutation_sequencer.sv
// ---------------------------------------------------------------------------
// permutation_sequencer
//
// Round sequencer for an ASCON p^a / p^b permutation datapath. On an accepted
// start it walks the round index from (12 - N) up to 11, one round per cycle,
// steering the datapath input mux (initial state vs. state register) and the
// state-register capture enable, then pulses done_o for one cycle.
//
// Ports
//   clock_i     in   single clock, rising edge
//   reset_i     in   synchronous active-high reset
//   start_i     in   permutation request, honoured only while ready_o=1
//   mode_i      in   0: p^a (NB_ROUNDS_A rounds), 1: p^b (NB_ROUNDS_B rounds)
//   ready_o     out  idle, a start will be accepted
//   round_o     out  round index for the constant-addition layer
//   sel_init_o  out  1: feed external initial state, 0: feed state register
//   en_state_o  out  state-register capture enable
//   busy_o      out  permutation rounds in progress
//   done_o      out  one-cycle pulse, result valid in the state register
// ---------------------------------------------------------------------------

package ascon_pack;

    localparam int unsigned ROUND_W    = 4;
    localparam int unsigned MAX_ROUNDS = 12;

    // Index of the final round of every ASCON permutation.
    localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd11;

endpackage : ascon_pack

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i, counter held at 0
// FIRST | first round, datapath reads the external initial state
// ROUND | remaining rounds, datapath reads the state register
// DONE  | result valid, one-cycle done_o pulse, back to IDLE
module permutation_sequencer
    import ascon_pack::*;
#(
    parameter int unsigned NB_ROUNDS_A = 12,
    parameter int unsigned NB_ROUNDS_B = 6
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               mode_i,
    output logic               ready_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               sel_init_o,
    output logic               en_state_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A permutation with N rounds uses the last N round constants.
    localparam logic [ROUND_W-1:0] START_A = ROUND_W'(MAX_ROUNDS - NB_ROUNDS_A);
    localparam logic [ROUND_W-1:0] START_B = ROUND_W'(MAX_ROUNDS - NB_ROUNDS_B);

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               mode_q,  mode_d;

    logic               last_round;
    logic               first_is_last;

    assign last_round = (round_q == LAST_ROUND);

    // In FIRST the counter holds the start value of the latched mode, so it
    // sits at 11 exactly when that mode is a single-round permutation.
    assign first_is_last = mode_q ? (START_B == LAST_ROUND) : (START_A == LAST_ROUND);

    // ---------------- state register ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    // ---------------- next state / counter ----------------
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        mode_d  = mode_q;

        unique case (state_q)
            IDLE: begin
                round_d = '0;
                if (start_i) begin
                    mode_d  = mode_i;
                    round_d = mode_i ? START_B : START_A;
                    state_d = FIRST;
                end
            end

            FIRST: begin
                if (first_is_last) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = ROUND;
                end
            end

            ROUND: begin
                // Terminal-count compare stops the counter at 11; it never wraps.
                if (last_round) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            DONE: begin
                round_d = '0;
                state_d = IDLE;
            end

            default: begin
                round_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- outputs (registers only) ----------------
    always_comb begin
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        sel_init_o = 1'b0;
        en_state_o = 1'b0;
        round_o    = round_q;

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            FIRST: begin
                busy_o     = 1'b1;
                sel_init_o = 1'b1;
                en_state_o = 1'b1;
            end
            ROUND: begin
                busy_o     = 1'b1;
                en_state_o = 1'b1;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

endmodule : permutation_sequencer
